signal_frame_streamer: RTL and testbench
========================================

Name: signal_frame_streamer

Overview:
- Parametrised successor to the ROM-backed test-signal source feeding the 1D-conv/FFT path.
- Reads a stored vibration record from a synchronous ROM in fixed-length frames, one frame per programmable slot period.
- Emits samples with explicit valid/first/last markers, a frame index, and a done flag.
- Adds configurable ROM read latency, run/pause control, truncated final frame, and optional wrap-around replay.

Parameters:
DATA_W, 16, sample width
ADDR_W, 19, ROM address width
FRAME_LEN, 2048, samples per frame
FRAME_PERIOD, 18001, cycles per frame slot; must be >= FRAME_LEN+ROM_LAT+2
TOTAL_SAMPLES, 512000, samples stored in ROM (addresses 0..TOTAL_SAMPLES-1)
ROM_LAT, 1, ROM read latency in cycles (1..4)
WRAP_EN, 0, 1 = restart at address 0 after the record ends; 0 = stop

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
run  in  1  1 = advance; 0 = pause slot counter and reads
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_data  in  DATA_W  ROM data, valid ROM_LAT cycles after rom_en
sample_out  out  DATA_W  output sample; forced 0 when sample_valid=0
sample_valid  out  1  sample_out valid this cycle
frame_first  out  1  first sample of a frame (qualified by valid)
frame_last  out  1  last sample of a frame, including a truncated one
frame_idx  out  16  index of the current frame; wraps modulo 2^16
done  out  1  record exhausted with WRAP_EN=0; sticky until reset

Behaviour:
- Reset (reset=0 at a clk edge) clears all state. Outputs rom_en, rom_addr, sample_out, sample_valid, frame_first, frame_last, frame_idx and done all go to 0. Any in-flight read pipeline is discarded.
- Slot counter cnt runs 0..FRAME_PERIOD-1, then returns to 0. It advances only when run=1 and done=0.
- Read phase:
  - rom_en=1 in every cycle with run=1, cnt<FRAME_LEN, rom_addr<TOTAL_SAMPLES and done=0.
  - rom_addr increments after each issued read.
- A read issued at cycle t produces sample_valid=1 and sample_out=rom_data at cycle t+ROM_LAT+1 (registered output).
- Pipeline: a valid/first/last tag shift register of depth ROM_LAT travels alongside the reads.
  - Lowering run stops new reads only; reads already issued still drain to the output.
- frame_first is tagged on the read issued at cnt=0.
- frame_last is tagged on the read issued at cnt=FRAME_LEN-1, or on the read of address TOTAL_SAMPLES-1, whichever comes first.
- frame_idx increments one cycle after the frame_last sample is output.
- End of record:
  - WRAP_EN=0: after the last address is read, no further reads occur. done rises in the cycle after the final frame_last output, then the slot counter stops.
  - WRAP_EN=1: rom_addr reloads to 0 at the next cnt=0. The remainder of the current slot stays idle, so frames always start at address k*FRAME_LEN modulo the record. done stays 0.
- A truncated final frame has fewer than FRAME_LEN samples. It is still marked first/last and counted in frame_idx.
- Idle: sample_out=0, frame_first=0 and frame_last=0 whenever sample_valid=0.
- Reset mid-frame: the next frame restarts at address 0 and no partial-frame tail is emitted.
- Widths: rom_addr compares are ADDR_W-bit unsigned; cnt is ceil(log2(FRAME_PERIOD)) bits.

Test Plan:
All scenarios use FRAME_LEN=8, FRAME_PERIOD=20, TOTAL_SAMPLES=20, ROM_LAT=2. The ROM model returns addr+100.
1. Reset released, run=1:
   - rom_en is high for 8 cycles with addresses 0..7.
   - sample_valid first goes high 3 cycles after the first rom_en, with value 100 and frame_first=1.
   - The 8th sample is 107 with frame_last=1; frame_idx then reads 1.
2. Continue running: frames start at addresses 8 and 16.
   - The third frame is truncated to 4 samples (116..119), with frame_last on 119.
   - done rises one cycle later and no further rom_en occurs.
3. WRAP_EN=1: after sample 119, rom_en stays low until the next cnt=0. Address 0 then restarts and frame_idx=3.
4. Drop run for 5 cycles after address 3 is issued:
   - Samples 102 and 103 still appear.
   - No rom_en occurs during the pause.
   - On resume, addresses 4..7 follow; the frame still contains exactly 8 samples, in order.
5. Assert reset for 1 cycle mid-frame at address 5:
   - All outputs are 0 the next cycle and in-flight samples are dropped.
   - After release, the frame restarts at address 0 with frame_idx=0.
6. ROM_LAT=4, default geometry otherwise:
   - Latency from rom_en to sample_valid is 5 cycles.
   - sample_out is 0 whenever valid is low.

Source files
------------

// File: rtl/signal_frame_streamer.sv
// Frame-slotted ROM sample streamer: reads a stored record in fixed-length
// frames, one frame per slot period, and emits valid/first/last-tagged samples
// with a running frame index and an end-of-record done flag.
module signal_frame_streamer #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned FRAME_LEN     = 2048,
  parameter int unsigned FRAME_PERIOD  = 18001,
  parameter int unsigned TOTAL_SAMPLES = 512000,
  parameter int unsigned ROM_LAT       = 1,
  parameter bit          WRAP_EN       = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              frame_first,
  output logic              frame_last,
  output logic [15:0]       frame_idx,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(FRAME_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST_RD = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_END     = CNT_W'(FRAME_PERIOD - 1);
  localparam logic [ADDR_W-1:0] ADDR_END    = ADDR_W'(TOTAL_SAMPLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(TOTAL_SAMPLES - 1);

  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               can_issue;

  // Tags launched together with each read (stage 0 of the tag pipeline).
  logic               tag_first;
  logic               tag_last;
  logic               tag_eor;

  logic [ROM_LAT-1:0] vld_pipe;
  logic [ROM_LAT-1:0] first_pipe;
  logic [ROM_LAT-1:0] last_pipe;
  logic [ROM_LAT-1:0] eor_pipe;
  logic               eor_out;

  // A read goes out in the read window of the slot while record data remains.
  always_comb begin
    can_issue = run && !done && (cnt <= CNT_LAST_RD) && (rd_ptr < ADDR_END);
  end

  // Slot counter, read pointer and registered ROM request with its tags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      rd_ptr    <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      tag_first <= 1'b0;
      tag_last  <= 1'b0;
      tag_eor   <= 1'b0;
    end else begin
      rom_en    <= 1'b0;
      tag_first <= 1'b0;
      tag_last  <= 1'b0;
      tag_eor   <= 1'b0;
      if (run && !done) begin
        if (cnt == CNT_END) begin
          cnt <= '0;
          // Reload only at a slot boundary so frames stay aligned to k*FRAME_LEN.
          if (WRAP_EN && (rd_ptr >= ADDR_END)) begin
            rd_ptr <= '0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (can_issue) begin
        rom_en    <= 1'b1;
        rom_addr  <= rd_ptr;
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        tag_first <= (cnt == '0);
        tag_last  <= (cnt == CNT_LAST_RD) || (rd_ptr == ADDR_LAST);
        tag_eor   <= (rd_ptr == ADDR_LAST);
      end
    end
  end

  // Tag shift register tracking reads through the ROM latency; never stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      eor_pipe   <= '0;
    end else begin
      vld_pipe[0]   <= rom_en;
      first_pipe[0] <= tag_first;
      last_pipe[0]  <= tag_last;
      eor_pipe[0]   <= tag_eor;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
        eor_pipe[i]   <= eor_pipe[i-1];
      end
    end
  end

  // Registered sample output, frame index and sticky end-of-record flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_valid <= 1'b0;
      sample_out   <= '0;
      frame_first  <= 1'b0;
      frame_last   <= 1'b0;
      eor_out      <= 1'b0;
      frame_idx    <= '0;
      done         <= 1'b0;
    end else begin
      sample_valid <= vld_pipe[ROM_LAT-1];
      sample_out   <= vld_pipe[ROM_LAT-1] ? rom_data : '0;
      frame_first  <= vld_pipe[ROM_LAT-1] & first_pipe[ROM_LAT-1];
      frame_last   <= vld_pipe[ROM_LAT-1] & last_pipe[ROM_LAT-1];
      eor_out      <= vld_pipe[ROM_LAT-1] & eor_pipe[ROM_LAT-1];
      if (sample_valid && frame_last) begin
        frame_idx <= frame_idx + 16'd1;
      end
      if (!WRAP_EN && sample_valid && frame_last && eor_out) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_signal_frame_streamer.sv
// Scoreboard bench for signal_frame_streamer: three instances (stop at end,
// wrap-around, 4-cycle ROM latency) on small geometry, ROM returns addr+100.
`timescale 1ns/1ps
module tb_signal_frame_streamer;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
    logic [15:0] idx;
  } samp_t;

  typedef struct packed {
    logic [7:0] addr;
    int         rel;
  } rd_t;

  logic              clk = 1'b0;
  logic [2:0]        reset;
  logic [2:0]        run;
  logic [2:0]        rom_en;
  logic [2:0][7:0]   rom_addr;
  logic [2:0][15:0]  rom_data;
  logic [2:0][15:0]  sample_out;
  logic [2:0]        sample_valid;
  logic [2:0]        frame_first;
  logic [2:0]        frame_last;
  logic [2:0][15:0]  frame_idx;
  logic [2:0]        done;

  logic [15:0] rp [3][4];

  samp_t sq [3][$];
  rd_t   rq [3][$];
  int    lq [3][$];
  int    base [3];
  bit    exp_done [3];
  int    lat_c [3]  = '{3, 3, 5};
  bit    wrap_c [3] = '{1'b0, 1'b1, 1'b0};

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  signal_frame_streamer #(.DATA_W(16), .ADDR_W(8), .FRAME_LEN(8), .FRAME_PERIOD(20),
    .TOTAL_SAMPLES(20), .ROM_LAT(2), .WRAP_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .run(run[0]), .rom_en(rom_en[0]), .rom_addr(rom_addr[0]),
    .rom_data(rom_data[0]), .sample_out(sample_out[0]), .sample_valid(sample_valid[0]),
    .frame_first(frame_first[0]), .frame_last(frame_last[0]), .frame_idx(frame_idx[0]),
    .done(done[0]));

  signal_frame_streamer #(.DATA_W(16), .ADDR_W(8), .FRAME_LEN(8), .FRAME_PERIOD(20),
    .TOTAL_SAMPLES(20), .ROM_LAT(2), .WRAP_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .run(run[1]), .rom_en(rom_en[1]), .rom_addr(rom_addr[1]),
    .rom_data(rom_data[1]), .sample_out(sample_out[1]), .sample_valid(sample_valid[1]),
    .frame_first(frame_first[1]), .frame_last(frame_last[1]), .frame_idx(frame_idx[1]),
    .done(done[1]));

  signal_frame_streamer #(.DATA_W(16), .ADDR_W(8), .FRAME_LEN(8), .FRAME_PERIOD(20),
    .TOTAL_SAMPLES(20), .ROM_LAT(4), .WRAP_EN(1'b0)) u_dut2 (
    .clk(clk), .reset(reset[2]), .run(run[2]), .rom_en(rom_en[2]), .rom_addr(rom_addr[2]),
    .rom_data(rom_data[2]), .sample_out(sample_out[2]), .sample_valid(sample_valid[2]),
    .frame_first(frame_first[2]), .frame_last(frame_last[2]), .frame_idx(frame_idx[2]),
    .done(done[2]));

  // Synchronous ROM models with 2, 2 and 4 cycles of latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rp[i][0] <= rom_en[i] ? (16'(rom_addr[i]) + 16'd100) : 16'hdead;
      for (int j = 1; j < 4; j++) rp[i][j] <= rp[i][j-1];
    end
  end
  assign rom_data[0] = rp[0][1];
  assign rom_data[1] = rp[1][1];
  assign rom_data[2] = rp[2][3];

  task automatic chk(input string name, input int id, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h (cycle %0d)", name, id, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input int id, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s dut%0d got %0h expected nothing (cycle %0d)", name, id, act, cyc);
  endtask

  task automatic push_run(input int id, input int a0, input int n, input int idx,
                          input int rel0);
    for (int k = 0; k < n; k++) begin
      rq[id].push_back('{addr: 8'(a0 + k), rel: rel0 + k});
      sq[id].push_back('{data: 16'(100 + a0 + k), first: (k == 0), last: (k == n - 1),
                         idx: 16'(idx)});
    end
  endtask

  task automatic wait_addr(input int id, input logic [7:0] a);
    bit found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (rom_en[id] && rom_addr[id] == a) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) flag("timeout_wait_addr", id, 64'(a));
  endtask

  // Monitor: pops expected samples/reads whenever the DUT presents them.
  always @(negedge clk) begin : monitor
    samp_t se;
    rd_t   re;
    for (int i = 0; i < 3; i++) begin
      if (sample_valid[i]) begin
        if (sq[i].size() == 0) flag("unexpected_sample", i, 64'(sample_out[i]));
        else begin
          se = sq[i].pop_front();
          chk("sample_data", i, 64'(sample_out[i]), 64'(se.data));
          chk("frame_first", i, 64'(frame_first[i]), 64'(se.first));
          chk("frame_last", i, 64'(frame_last[i]), 64'(se.last));
          chk("frame_idx", i, 64'(frame_idx[i]), 64'(se.idx));
        end
        if (lq[i].size() == 0) flag("sample_without_read", i, 64'(sample_out[i]));
        else chk("latency", i, 64'(cyc - lq[i].pop_front()), 64'(lat_c[i]));
      end else begin
        chk("idle_zero", i, {sample_out[i], frame_first[i], frame_last[i]}, 64'd0);
      end
      if (rom_en[i]) begin
        if (rq[i].size() == 0) flag("unexpected_rom_en", i, 64'(rom_addr[i]));
        else begin
          re = rq[i].pop_front();
          if (re.rel == 0) base[i] = cyc;
          chk("rom_addr", i, 64'(rom_addr[i]), 64'(re.addr));
          chk("read_slot_time", i, 64'(cyc - base[i]), 64'(re.rel));
        end
        lq[i].push_back(cyc);
      end
      chk("done", i, 64'(done[i]), 64'(exp_done[i]));
      if (!wrap_c[i] && sample_valid[i] && frame_last[i] && sample_out[i] == 16'd119)
        exp_done[i] = 1'b1;
      if (!reset[i]) begin
        lq[i].delete();
        exp_done[i] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 3'b000;
    run   = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk("reset_state", i, {rom_en[i], rom_addr[i], sample_out[i], sample_valid[i],
          frame_first[i], frame_last[i], frame_idx[i], done[i]}, 64'd0);

    // Full record: frames at 0, 8, 16 (truncated to 4); wrap instance replays.
    push_run(0, 0, 8, 0, 0);  push_run(0, 8, 8, 1, 20);  push_run(0, 16, 4, 2, 40);
    push_run(2, 0, 8, 0, 0);  push_run(2, 8, 8, 1, 20);  push_run(2, 16, 4, 2, 40);
    push_run(1, 0, 8, 0, 0);  push_run(1, 8, 8, 1, 20);  push_run(1, 16, 4, 2, 40);
    push_run(1, 0, 8, 3, 60); push_run(1, 8, 8, 4, 80);
    reset = 3'b111;
    repeat (90) @(posedge clk);
    #1 run[1] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("done_sticky", 0, 64'(done[0]), 64'd1);
    chk("done_sticky", 2, 64'(done[2]), 64'd1);
    chk("done_wrap", 1, 64'(done[1]), 64'd0);

    // Pause after address 3: reads 4..7 resume 5 cycles later.
    reset[0] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      rq[0].push_back('{addr: 8'(k), rel: (k < 4) ? k : k + 5});
      sq[0].push_back('{data: 16'(100 + k), first: (k == 0), last: (k == 7), idx: 16'd0});
    end
    reset[0] = 1'b1;
    wait_addr(0, 8'd3);
    run[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 run[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Reset mid-frame at address 5: only samples 100..102 emerge before it.
    reset[0] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) rq[0].push_back('{addr: 8'(k), rel: k});
    for (int k = 0; k < 3; k++)
      sq[0].push_back('{data: 16'(100 + k), first: (k == 0), last: 1'b0, idx: 16'd0});
    reset[0] = 1'b1;
    wait_addr(0, 8'd5);
    reset[0] = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_frame", 0, {rom_en[0], rom_addr[0], sample_out[0], sample_valid[0],
        frame_first[0], frame_last[0], frame_idx[0], done[0]}, 64'd0);
    push_run(0, 0, 8, 0, 0);
    reset[0] = 1'b1;
    repeat (14) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      chk("drain_reads", i, 64'(rq[i].size()), 64'd0);
      chk("drain_samples", i, 64'(sq[i].size()), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
